// File: rtl/approx_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : approx_error_monitor
// Purpose  : Measures the error of an 8-bit approximate adder. For each
//            sample it rebuilds the exact sum and forms the error distance
//            ED = |exact - approx_sum|. Over a window of 2^WIN_LOG2 samples
//            it accumulates the error count, the ED sum and the maximum ED,
//            then presents them on a valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
module approx_error_monitor #(
    parameter int WIN_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            a,
    input  logic [7:0]            b,
    input  logic [8:0]            approx_sum,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIN_LOG2:0]     err_count,
    output logic [WIN_LOG2+8:0]   ed_sum,
    output logic [8:0]            ed_max
);

    // Window length and the count value held while the last sample is accepted
    localparam logic [WIN_LOG2:0] c_WIN_LEN = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [WIN_LOG2:0] c_LAST    = {1'b0, {WIN_LOG2{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WIN_LOG2:0]     cnt_q, cnt_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [8:0]            s1_ed_q, s1_ed_d;
    logic [WIN_LOG2:0]     err_count_q, err_count_d;
    logic [WIN_LOG2+8:0]   ed_sum_q, ed_sum_d;
    logic [8:0]            ed_max_q, ed_max_d;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_start;
    logic [8:0]            w_exact;
    logic [8:0]            w_ed;

    // Handshake qualifiers; in_ready depends only on state and count
    assign w_ready  = (state_q == ST_ACCUM) && (cnt_q < c_WIN_LEN);
    assign w_accept = in_valid & w_ready;
    assign w_start  = start & (state_q == ST_IDLE);

    // Exact sum and absolute distance to the adder-under-test output
    assign w_exact = {1'b0, a} + {1'b0, b};
    assign w_ed    = (w_exact >= approx_sum) ? (w_exact - approx_sum)
                                             : (approx_sum - w_exact);

    // Next-state logic of the window controller
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)                              state_d = ST_ACCUM;
            ST_ACCUM:  if (w_accept && (cnt_q == c_LAST))      state_d = ST_DRAIN;
            ST_DRAIN:                                          state_d = ST_REPORT;
            ST_REPORT: if (res_ready)                          state_d = ST_IDLE;
            default:                                           state_d = ST_IDLE;
        endcase
    end

    // Two-stage datapath: stage 1 captures ED on accept, stage 2 accumulates it
    always_comb begin
        cnt_d       = cnt_q;
        s1_valid_d  = w_accept;
        s1_ed_d     = s1_ed_q;
        err_count_d = err_count_q;
        ed_sum_d    = ed_sum_q;
        ed_max_d    = ed_max_q;

        if (w_accept) begin
            s1_ed_d = w_ed;
            cnt_d   = cnt_q + 1'b1;
        end

        if (s1_valid_q) begin
            ed_sum_d    = ed_sum_q + {{WIN_LOG2{1'b0}}, s1_ed_q};
            err_count_d = err_count_q + {{WIN_LOG2{1'b0}}, (s1_ed_q != 9'd0)};
            if (s1_ed_q > ed_max_q) begin
                ed_max_d = s1_ed_q;
            end
        end

        // A new window starts from a clean slate
        if (w_start) begin
            cnt_d       = '0;
            s1_valid_d  = 1'b0;
            err_count_d = '0;
            ed_sum_d    = '0;
            ed_max_d    = '0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset aborts any window in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_ed_q     <= '0;
            err_count_q <= '0;
            ed_sum_q    <= '0;
            ed_max_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_ed_q     <= s1_ed_d;
            err_count_q <= err_count_d;
            ed_sum_q    <= ed_sum_d;
            ed_max_q    <= ed_max_d;
        end
    end

    assign in_ready  = w_ready;
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_REPORT);
    assign err_count = err_count_q;
    assign ed_sum    = ed_sum_q;
    assign ed_max    = ed_max_q;

endmodule
`default_nettype wire

// File: doc/approx_error_monitor.md
# approx_error_monitor

Downstream characterisation stage for the 8-bit approximate adders (lower-part OR / upper-part Brent-Kung family). It takes each operand pair together with the approximate 9-bit sum produced by the adder under test. It recomputes the exact sum, forms the error distance (ED), and accumulates error statistics over a fixed window of samples. At the end of each window it reports the error count, the ED sum (from which the bench derives MED) and the maximum ED through a valid/ready result handshake.

## Interface
- WIN_LOG2, default 8: window length is 2^WIN_LOG2 accepted samples; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse that begins a window; honoured only in IDLE.
- in_valid  in  1  sample present on a/b/approx_sum.
- in_ready  out  1  monitor accepts a sample this cycle.
- a, b  in  8 each  operands fed to the adder under test.
- approx_sum  in  9  adder-under-test output for a, b.
- busy  out  1  high in any state other than IDLE.
- res_valid  out  1  window results available.
- res_ready  in  1  consumer takes the results.
- err_count  out  WIN_LOG2+1  number of samples with ED ≠ 0.
- ed_sum  out  WIN_LOG2+9  sum of ED over the window.
- ed_max  out  9  largest ED in the window.

## Operation
- States: IDLE, ACCUM, DRAIN, REPORT.
- Reset (async, rst_n=0):
  - state IDLE; all counters, accumulators and the stage-1 register cleared.
  - in_ready=0, busy=0, res_valid=0, err_count=0, ed_sum=0, ed_max=0.
- IDLE:
  - start=1 clears the sample counter, err_count, ed_sum, ed_max and the stage-1 valid flag, then moves to ACCUM.
  - start is ignored in every other state.
- ACCUM:
  - in_ready = 1 while accepted-sample count < 2^WIN_LOG2.
  - Accept means in_valid & in_ready at a rising edge.
- Stage 1 (on accept):
  - exact = a + b, zero-extended to 9 bits.
  - ED = |exact − approx_sum|, 9 bits unsigned, range 0..511.
  - ED and a valid flag are registered; the sample counter increments.
  - In a cycle with no accept, the stage-1 valid flag clears (bubble, no accumulation).
- Stage 2 (stage-1 valid set):
  - ed_sum += ED.
  - err_count += (ED ≠ 0).
  - ed_max = max(ed_max, ED).
- Transitions:
  - ACCUM → DRAIN: on the edge accepting sample number 2^WIN_LOG2.
  - DRAIN → REPORT: after one cycle, once the final stage-1 entry is accumulated.
  - REPORT: res_valid=1 and all result outputs held stable.
  - REPORT → IDLE: on res_valid & res_ready.
- After returning to IDLE, results keep their values until the next start.
- Widths are chosen so nothing can overflow: the worst case 2^WIN_LOG2 × 511 fits in ed_sum, and err_count reaches at most 2^WIN_LOG2.
- approx_sum is never interpreted. ED is purely the arithmetic distance, so both under- and over-estimating adders are handled.
- An asynchronous reset in any state aborts the window; no partial results are reported.

## Timing
- in_ready is combinational from state and count only; it never depends on in_valid.
- Accept at edge T: the sample's ED is registered at T, then accumulated at edge T+1.
- If the final sample is accepted at edge T:
  - state is DRAIN in cycle T..T+1;
  - res_valid is high from the cycle after edge T+1 (2 edges after the final accept).
- in_ready drops in the cycle immediately after the final accept.
- Throughput is one sample per clock with no required gaps; in_valid gaps just stretch the window.
- res_valid stays high for as long as res_ready is low.
- A handshake at edge R puts the block in IDLE (busy=0) from R; a start in the cycle after R is honoured.

## Test plan
- **Exact adder, zero error:** WIN_LOG2=2; approx_sum = a+b for 4 random pairs → err_count=0, ed_sum=0, ed_max=0, res_valid 2 edges after the 4th accept.
- **Mixed window:** WIN_LOG2=2; approximate adder driving approx_sum with pairs (0x0F,0x01)→15 vs 16, (0x0C,0x0C)→20 vs 24, (0x10,0x20)→48 vs 48, (0xFF,0xFF)→503 vs 510 → err_count=3, ed_sum=12, ed_max=7.
- **Input stalls:** same samples as the mixed window, with in_valid deasserted for 3 cycles between each pair → identical results; in_ready stays 1 until the 4th accept, then 0.
- **Result backpressure:** res_ready held 0 for 5 cycles in REPORT → outputs stable and start pulses ignored. Then res_ready=1 → IDLE next cycle, and a fresh start clears the results to 0.
- **Reset mid-window:** rst_n pulled low after 2 of 4 accepts → all outputs 0 immediately and state IDLE. A new window of 4 zero-error samples then reports err_count=0 with no carry-over.
- **Worst-case width:** WIN_LOG2=8; 256 samples of a=b=0, approx_sum=0x1FF → ed_sum=130816, ed_max=511, err_count=256, with no overflow.
